// File: rtl/async_rr_merge.sv
// Round-robin pull merge: fetches one token at a time from the enabled upstream
// channels and delivers it, tagged with its source index, to a single consumer.
module async_rr_merge #(
  parameter int num_inputs = 2,
  parameter int data_width = 32,
  localparam int src_width = (num_inputs > 2) ? $clog2(num_inputs) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [num_inputs-1:0]            req_l,
  input  logic [num_inputs-1:0]            ack_l,
  input  logic [data_width*num_inputs-1:0] din,
  input  logic [num_inputs-1:0]            src_en,
  input  logic                             req_r,
  output logic                             ack_r,
  output logic [data_width-1:0]            dout,
  output logic [src_width-1:0]             dout_src,
  output logic [31:0]                      count
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t                  state_q, state_d;
  logic [src_width-1:0]    ptr_q, ptr_d;
  logic [src_width-1:0]    grant_q, grant_d;
  logic [num_inputs-1:0]   req_l_q, req_l_d;
  logic                    ack_r_q, ack_r_d;
  logic [data_width-1:0]   dout_q, dout_d;
  logic [src_width-1:0]    dout_src_q, dout_src_d;
  logic [31:0]             count_q, count_d;
  logic [data_width-1:0]   buf_data_q, buf_data_d;
  logic [src_width-1:0]    buf_src_q, buf_src_d;

  logic                    sel_valid;
  logic [src_width-1:0]    sel_idx;
  logic                    grant_ack;

  // Scan from ptr upward (mod num_inputs); the last hit of a descending walk is the nearest.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = num_inputs - 1; k >= 0; k--) begin
      automatic int idx = (int'(ptr_q) + k) % num_inputs;
      if (src_en[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = src_width'(idx);
      end
    end
  end

  assign grant_ack = ack_l[grant_q];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_valid) state_d = FETCH;
      FETCH:   if (grant_ack) state_d = FULL;
      FULL:    if (req_r && !ack_r_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_l_d    = req_l_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    ack_r_d    = 1'b0;
    dout_d     = dout_q;
    dout_src_d = dout_src_q;
    count_d    = count_q;
    buf_data_d = buf_data_q;
    buf_src_d  = buf_src_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d          = sel_idx;
          req_l_d          = '0;
          req_l_d[sel_idx] = 1'b1;
        end
      end
      FETCH: begin
        // Only the granted channel's ack is honoured; stray acks elsewhere are ignored.
        if (grant_ack) begin
          buf_data_d = din[int'(grant_q)*data_width +: data_width];
          buf_src_d  = grant_q;
          req_l_d    = '0;
        end
      end
      FULL: begin
        req_l_d = '0;
        if (req_r && !ack_r_q) begin
          ack_r_d    = 1'b1;
          dout_d     = buf_data_q;
          dout_src_d = buf_src_q;
          count_d    = count_q + 32'd1;
          ptr_d      = (grant_q == src_width'(num_inputs - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: req_l_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      req_l_q    <= '0;
      ack_r_q    <= 1'b0;
      dout_q     <= '0;
      dout_src_q <= '0;
      count_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      req_l_q    <= req_l_d;
      ack_r_q    <= ack_r_d;
      dout_q     <= dout_d;
      dout_src_q <= dout_src_d;
      count_q    <= count_d;
    end
  end

  // One-token buffer; a reset simply strands its contents since state returns to IDLE.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_src_q  <= buf_src_d;
  end

  assign req_l    = req_l_q;
  assign ack_r    = ack_r_q;
  assign dout     = dout_q;
  assign dout_src = dout_src_q;
  assign count    = count_q;

endmodule

// File: tb/tb_async_rr_merge.sv
// Scoreboard bench for async_rr_merge with three fabric-style producers.
module tb_async_rr_merge;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_l;
  logic [N-1:0]    ack_l;
  logic [DW*N-1:0] din;
  logic [N-1:0]    src_en;
  logic            req_r;
  logic            ack_r;
  logic [DW-1:0]   dout;
  logic [SW-1:0]   dout_src;
  logic [31:0]     count;

  async_rr_merge #(.num_inputs(N), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
    .src_en(src_en), .req_r(req_r), .ack_r(ack_r), .dout(dout),
    .dout_src(dout_src), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [SW+DW-1:0] exp_q[$];
  int mode = 0;          // 0: acks low, 1: toggle acks, 2: fabric producers
  logic stray = 1'b0;
  logic chk_spacing = 1'b0;
  int onehot_bad = 0;
  logic [N-1:0] seen_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_tok(input int src, input int val);
    exp_q.push_back({SW'(src), DW'(val)});
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_l"}, 64'(req_l), 0);
    chk({tag, "_ack_r"}, 64'(ack_r), 0);
    chk({tag, "_dout"}, 64'(dout), 0);
    chk({tag, "_dout_src"}, 64'(dout_src), 0);
    chk({tag, "_count"}, 64'(count), 0);
  endtask

  task automatic wait_acks(input int n, input string name);
    int k = 0;
    for (int c = 0; c < 80 && k < n; c++) begin
      step();
      seen_req |= req_l;
      if (ack_r === 1'b1) k++;
    end
    if (k < n) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d acks expected %0d", name, k, n);
    end
  endtask

  // Producers: ack one cycle after sampling req, guarded by ~ack; values count from base.
  initial begin
    int cnt[N];
    int base[N];
    logic [N-1:0] prev_req, nxt;
    base = '{0, 100, 200};
    cnt = '{0, 0, 0};
    ack_l = '0;
    din = '0;
    prev_req = '0;
    forever begin
      @(posedge clk);
      #1;
      nxt = '0;
      for (int i = 0; i < N; i++) begin
        if (mode == 1) nxt[i] = ~ack_l[i];
        else if (mode == 2 && prev_req[i] && !ack_l[i]) begin
          nxt[i] = 1'b1;
          din[i*DW +: DW] = DW'(base[i] + cnt[i]);
          cnt[i]++;
        end
      end
      if (stray) begin
        nxt[1] = 1'b1;
        din[DW +: DW] = 16'hDEAD;
      end
      ack_l = nxt;
      prev_req = req_l;
    end
  end

  // Monitor: compares every delivered token against the scoreboard head.
  initial begin
    int cyc = 0;
    int last_ack = 0;
    logic have_last = 1'b0;
    logic [SW+DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if ($countones(req_l) > 1) onehot_bad++;
      if (ack_r === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_token: got src %0d data %0h expected none", dout_src, dout);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_src_data", 64'({dout_src, dout}), 64'(e));
        end
        if (chk_spacing) begin
          if (have_last) chk("ack_spacing", 64'(cyc - last_ack), 4);
          have_last = 1'b1;
          last_ack = cyc;
        end else have_last = 1'b0;
      end
    end
  end

  initial begin
    logic done;
    rst = 1'b1;
    req_r = 1'b0;
    src_en = '0;
    mode = 1;

    // Reset held two cycles while ack_l and req_r toggle.
    for (int i = 0; i < 2; i++) begin
      step();
      req_r = ~req_r;
      chk_reset_outs("reset");
    end
    rst = 1'b0;
    mode = 0;
    req_r = 1'b1;
    step();
    chk_reset_outs("post_reset");

    // Fairness between channels 0 and 1 with an always-ready sink.
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      expect_tok(0, i);
      expect_tok(1, 100 + i);
    end
    chk_spacing = 1'b1;
    src_en = 3'b011;
    wait_acks(8, "fair");
    src_en = 3'b000;
    chk("fair_count", 64'(count), 8);
    step();
    chk_spacing = 1'b0;

    // Masking 3'b101 from a fresh reset, then switch to channel 1 only.
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_tok(0, 4);
    expect_tok(2, 200);
    expect_tok(0, 5);
    expect_tok(2, 201);
    seen_req = '0;
    src_en = 3'b101;
    wait_acks(4, "mask");
    src_en = 3'b010;
    chk("mask_no_req1", 64'(seen_req[1]), 0);
    step();
    chk("switch_sel_ch1", 64'(req_l), 64'(3'b010));
    expect_tok(1, 104);
    wait_acks(1, "switch");
    src_en = 3'b000;

    // Sink stall: hold the captured token for 20 cycles.
    req_r = 1'b0;
    src_en = 3'b001;
    expect_tok(0, 6);
    done = 1'b0;
    seen_req = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (req_l[0]) seen_req[0] = 1'b1;
      else if (seen_req[0]) done = 1'b1;
    end
    chk("stall_captured", 64'(done), 1);
    src_en = 3'b000;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_l != '0 || ack_r) done = 1'b1;
    end
    chk("stall_quiet", 64'(done), 0);
    chk("stall_count_held", 64'(count), 5);
    req_r = 1'b1;
    wait_acks(1, "stall_release");
    chk("stall_count_inc", 64'(count), 6);
    step();
    chk("ack_r_single_pulse", 64'(ack_r), 0);

    // Stray ack on channel 1 while channel 0 is being fetched.
    expect_tok(0, 7);
    src_en = 3'b001;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (req_l[0]) done = 1'b1;
    end
    chk("stray_fetch_started", 64'(done), 1);
    stray = 1'b1;
    step();
    stray = 1'b0;
    wait_acks(1, "stray");
    src_en = 3'b000;
    chk("stray_dout_held", 64'(dout), 7);

    // Reset on the very edge that samples the granted ack: token is dropped.
    expect_tok(0, 8);
    src_en = 3'b011;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (ack_l[1]) done = 1'b1;
    end
    chk("midfetch_ack_seen", 64'(done), 1);
    rst = 1'b1;
    step();
    chk_reset_outs("midfetch_reset");
    rst = 1'b0;
    step();
    chk("restart_ch0", 64'(req_l), 64'(3'b001));
    wait_acks(1, "restart");
    src_en = 3'b000;

    repeat (5) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    chk("req_l_onehot", 64'(onehot_bad), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/async_rr_merge.md
# async_rr_merge

Round-robin merge node for the asynchronous dataflow fabric. It pulls tokens from `num_inputs` upstream channels using the fabric's req/ack pull handshake, and buffers one token at a time. It then delivers that token, tagged with its source index, to a single downstream consumer. It is the arbiter used when several producers or operators share one downstream operator input. A per-channel enable mask lets the harness reconfigure which sources participate.

## Interface

Parameters:
- `num_inputs`, default 2: number of upstream channels; legal range ≥ 2.
- `data_width`, default 32: token width.
- `src_width` (localparam): `$clog2(num_inputs)`, minimum 1.

Ports:
- Clocking and reset. One clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  synchronous active-high reset.
- Upstream side:
  - `req_l`  out  num_inputs  per-channel pull request.
  - `ack_l`  in  num_inputs  per-channel ack; data is valid in the ack cycle.
  - `din`  in  data_width*num_inputs  channel i occupies bits [data_width*(i+1)-1 : data_width*i].
  - `src_en`  in  num_inputs  enable mask; 1 means the channel participates in arbitration.
- Downstream side:
  - `req_r`  in  1  downstream pull request.
  - `ack_r`  out  1  one-cycle delivery pulse.
  - `dout`  out  data_width  delivered token.
  - `dout_src`  out  src_width  index of the channel that produced `dout`.
- Status:
  - `count`  out  32  tokens delivered since reset.

## Operation

- Internal state:
  - `state` ∈ {IDLE, FETCH, FULL}.
  - `ptr` (src_width bits): round-robin start index.
  - `grant` (src_width bits).
  - `buf_data` (data_width bits) and `buf_src` (src_width bits).
- Reset values:
  - `state`=IDLE, `ptr`=0, `grant`=0.
  - `req_l`=0, `ack_r`=0, `dout`=0, `dout_src`=0, `count`=0.
  - Reset mid-transaction discards any captured or in-flight token.
- Selection (combinational):
  - Search for the first channel with `src_en`=1, scanning indices ptr, ptr+1, … modulo `num_inputs`.
  - `sel_valid` is 0 when `src_en` is all zeros.
- IDLE:
  - If `sel_valid`, register `grant`←selected index, set `req_l[grant]`←1, and go to FETCH.
  - Otherwise stay in IDLE.
  - Fetching does not wait for `req_r`; this gives a one-token prefetch.
- FETCH:
  - Hold `req_l[grant]`=1 until `ack_l[grant]`=1 is sampled.
  - On that edge: `buf_data`←din slice `grant`, `buf_src`←`grant`, `req_l[grant]`←0, go to FULL.
  - `ack_l` on non-granted channels is ignored and never captured.
  - Changes to `src_en` during FETCH do not abort the transaction.
- FULL:
  - All `req_l` are 0.
  - If `req_r`=1 and `ack_r`=0: `ack_r`←1, `dout`←`buf_data`, `dout_src`←`buf_src`, `count`←`count`+1 (wraps at 2^32), `ptr`←(`grant`+1) mod `num_inputs`, go to IDLE.
  - If `req_r`=0, remain in FULL indefinitely; the token is held and no new fetch starts.
- Output behaviour:
  - `ack_r` defaults to 0 each cycle, so it is always a single-cycle pulse.
  - `dout` and `dout_src` hold their values between deliveries.
- At most one `req_l` bit is ever high.
- `ptr` advances only on delivery, never on fetch.

## Timing

- Reference sources are fabric producers: they respond with ack one cycle after sampling req.
- Steady state with an always-ready sink and an always-ready source, counting edges:
  - E1: IDLE→FETCH, `req_l` rises.
  - E2: source asserts ack.
  - E3: capture, `req_l` falls, FULL.
  - E4: `ack_r`=1, IDLE.
- Throughput is one token per 4 cycles. Latency from `req_l` rise to `ack_r` is 3 cycles.
- `req_l` falls on the same edge the ack is sampled, so a producer guarded by ~ack never double-issues.
- Simultaneous events:
  - `rst`=1 overrides every transition in the same cycle.
  - A `src_en` change takes effect at the next IDLE selection.
  - When `src_en` is disabled for the channel at `ptr`, the search skips it without stalling.
- `ptr` wraps from `num_inputs`-1 to 0.

## Test plan

- Reset: assert `rst` 2 cycles while `ack_l`/`req_r` toggle → `req_l`=0, `ack_r`=0, `dout`=0, `dout_src`=0, `count`=0 throughout reset and on the first cycle after.
- Fairness, N=2, `src_en`=2'b11, producers counting from 0 and 100, sink always ready → `dout_src` sequence 0,1,0,1,…; `dout` 0,100,1,101,…; `ack_r` exactly every 4 cycles; `count`=8 after 8 pulses.
- Masking and wrap, N=3, `src_en`=3'b101 → `dout_src` sequence 0,2,0,2; `req_l[1]` never asserted; switching `src_en` to 3'b010 mid-run → the next selection from IDLE is channel 1.
- Sink stall: `req_r`=0 for 20 cycles after the first capture → state FULL, all `req_l`=0, no `ack_r`; when `req_r` rises, one `ack_r` pulse carries the buffered token and `count`+1.
- Stray ack: pulse `ack_l[1]`=1 with din=0xDEAD while `grant`=0 in FETCH → 0xDEAD never appears on `dout`; channel 0's token is delivered with `dout_src`=0.
- Reset mid-FETCH: assert `rst` on the edge where `ack_l[grant]`=1 → token dropped, all outputs at reset values; after release, arbitration restarts at channel 0.
